// File: rtl/vstore_mem_writer_pkg.sv
// Shared types for the vector store memory writer.
// Contents:
//   MemAddrWidth / VRFWordWidthB  default byte-address width and store word size in bytes
//   vrf_data_t / vrf_strb_t       store word and its byte-enable vector
//   insn_id_t / vlb_t             instruction id and byte-length types
//   vfu_e / vfu_req_t             launcher target unit and request payload
//   mem_req_t                     one memory write beat {addr, wdata, wstrb}
//   strb_from_bytes()             byte enables for the final, possibly partial, word
package vstore_mem_writer_pkg;

  localparam int MemAddrWidth  = 32;
  localparam int VRFWordWidthB = 8;
  localparam int VlBWidth      = 16;
  localparam int InsnIdWidth   = 4;

  typedef logic [8*VRFWordWidthB-1:0] vrf_data_t;
  typedef logic [VRFWordWidthB-1:0]   vrf_strb_t;
  typedef logic [InsnIdWidth-1:0]     insn_id_t;
  typedef logic [VlBWidth-1:0]        vlb_t;

  typedef enum logic [1:0] {
    VFU_ALU  = 2'd0,
    VFU_MFPU = 2'd1,
    VFU_VLU  = 2'd2,
    VFU_VSU  = 2'd3
  } vfu_e;

  typedef struct packed {
    vlb_t     vlB;
    insn_id_t insn_id;
  } vfu_req_t;

  typedef struct packed {
    logic [MemAddrWidth-1:0] addr;
    vrf_data_t               wdata;
    vrf_strb_t               wstrb;
  } mem_req_t;

  // Full word when at least a word's worth of bytes remain, otherwise the
  // low 'bytes' lanes only.
  function automatic vrf_strb_t strb_from_bytes(vlb_t bytes);
    vrf_strb_t strb;
    strb = '0;
    for (int i = 0; i < VRFWordWidthB; i++) begin
      strb[i] = (vlb_t'(i) < bytes);
    end
    return strb;
  endfunction

endpackage

// File: rtl/vstore_mem_writer.sv
// Turns deshuffled store words from the vector store unit into unit-stride
// memory write requests, tracks write responses and reports completion.
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   vfu_req_valid_i/ready_o, target_vfu_i, vfu_req_i, store_addr_i
//                                         instruction request (vlB, insn_id, base addr)
//   store_op_valid_i/gnt_o, store_op_i    store word stream
//   mem_req_o/gnt_i, mem_addr_o, mem_wdata_o, mem_wstrb_o
//                                         memory write request channel
//   mem_rvalid_i, mem_err_i               write responses
//   done_o, done_gnt_i, done_insn_id_o, done_err_o
//                                         completion report to the committer
//   stall_cnt_o                           cycles with mem_req_o & !mem_gnt_i
// Build option: define VSTORE_WRITER_PERF_EN to implement the stall counter;
// otherwise stall_cnt_o is tied to zero.
module vstore_mem_writer
  import vstore_mem_writer_pkg::*;
#(
  parameter int MemAddrWidth   = vstore_mem_writer_pkg::MemAddrWidth,
  parameter int MaxOutstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    vfu_req_valid_i,
  output logic                    vfu_req_ready_o,
  input  vfu_e                    target_vfu_i,
  input  vfu_req_t                vfu_req_i,
  input  logic [MemAddrWidth-1:0] store_addr_i,
  input  logic                    store_op_valid_i,
  output logic                    store_op_gnt_o,
  input  vrf_data_t               store_op_i,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output vrf_data_t               mem_wdata_o,
  output vrf_strb_t               mem_wstrb_o,
  input  logic                    mem_rvalid_i,
  input  logic                    mem_err_i,
  input  logic                    done_gnt_i,
  output logic                    done_o,
  output insn_id_t                done_insn_id_o,
  output logic                    done_err_o,
  output logic [31:0]             stall_cnt_o
);

  localparam int OffW = $clog2(VRFWordWidthB);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]              state;
  vlb_t                    bytes_left;
  insn_id_t                insn_id;
  logic [MemAddrWidth-1:0] next_addr;
  logic                    err;

  // Single-entry output register; holds still while mem_gnt_i is low.
  logic                    out_valid;
  logic [MemAddrWidth-1:0] out_addr;
  vrf_data_t               out_data;
  vrf_strb_t               out_strb;

  logic [CntW-1:0]         outstanding;

  logic accept, out_gnt, out_free, room, pop, last_pop;
  vlb_t bytes_rem;

  always_comb begin
    vfu_req_ready_o = (state == IDLE) || ((state == DONE) && done_gnt_i);
    accept   = vfu_req_valid_i && vfu_req_ready_o && (target_vfu_i == VFU_VSU);
    out_gnt  = out_valid && mem_gnt_i;
    out_free = !out_valid || mem_gnt_i;
    // The word still in the register counts against the limit: it becomes
    // outstanding as soon as it is granted.
    room     = (int'(outstanding) + int'(out_valid)) < MaxOutstanding;
    pop      = (state == SEND) && store_op_valid_i && out_free && room;
    last_pop = pop && (bytes_left <= vlb_t'(VRFWordWidthB));
    bytes_rem = (bytes_left >= vlb_t'(VRFWordWidthB)) ?
                (bytes_left - vlb_t'(VRFWordWidthB)) : '0;
  end

  assign store_op_gnt_o = pop;
  assign mem_req_o      = out_valid;
  assign mem_addr_o     = out_addr;
  assign mem_wdata_o    = out_data;
  assign mem_wstrb_o    = out_strb;
  assign done_o         = (state == DONE);
  assign done_err_o     = (state == DONE) && err;
  assign done_insn_id_o = insn_id;

  // Instruction FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      bytes_left <= '0;
      insn_id    <= '0;
      next_addr  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            bytes_left <= vfu_req_i.vlB;
            insn_id    <= vfu_req_i.insn_id;
            next_addr  <= {store_addr_i[MemAddrWidth-1:OffW], {OffW{1'b0}}};
            state      <= (vfu_req_i.vlB == '0) ? DONE : SEND;
          end else if ((state == DONE) && done_gnt_i) begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (pop) begin
            next_addr  <= next_addr + MemAddrWidth'(VRFWordWidthB);
            bytes_left <= bytes_rem;
            if (last_pop) state <= DRAIN;
          end
        end
        default: begin  // DRAIN
          if (!out_valid && (outstanding == '0)) state <= DONE;
        end
      endcase
    end
  end

  // Sticky per-instruction bus error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (mem_rvalid_i && mem_err_i) begin
      err <= 1'b1;
    end
  end

  // Output register: reload in the same cycle it is granted (no bubble)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_strb  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_addr  <= next_addr;
      out_data  <= store_op_i;
      out_strb  <= strb_from_bytes(bytes_left);
    end else if (out_gnt) begin
      out_valid <= 1'b0;
    end
  end

  // Granted-but-unacknowledged writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({out_gnt, mem_rvalid_i})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef VSTORE_WRITER_PERF_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (out_valid && !mem_gnt_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (outstanding != '0));
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> (store_addr_i[OffW-1:0] == '0));
`endif

endmodule
